// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned products into one result, with valid/ready on both sides and sticky overflow.
// Optional ACC_SATURATE_EN: clamp the accumulator at all-ones once it overflows instead of wrapping.
module product_accumulator #(
  parameter int unsigned PROD_W  = 8,
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned N_TERMS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  input  logic [PROD_W-1:0] i_product,
  output logic              o_sum_valid,
  input  logic              i_sum_ready,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_overflow,
  output logic [7:0]        o_term_count
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [7:0]         count_q;
  logic               sticky_q;
  logic [ACC_W-1:0]   sum_q;
  logic               ovf_q;
  logic               sum_valid_q;
  logic               prod_ready_q;

  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic               sticky_d;
  logic [ACC_W-1:0]   acc_add;
  logic [7:0]         count_next;
  logic               last_term;

  always_comb begin
    accept     = i_prod_valid & prod_ready_q;
    // One extra bit so the carry out of the top accumulator bit is visible.
    sum_ext    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_product};
    sticky_d   = sticky_q | sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
    acc_add    = sticky_d ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_add    = sum_ext[ACC_W-1:0];
`endif
    count_next = count_q + 8'd1;
    last_term  = (count_next == 8'(N_TERMS));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      count_q      <= '0;
      sticky_q     <= 1'b0;
      sum_q        <= '0;
      ovf_q        <= 1'b0;
      sum_valid_q  <= 1'b0;
      prod_ready_q <= 1'b0;
    end else if (i_clear) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      count_q      <= '0;
      sticky_q     <= 1'b0;
      sum_q        <= '0;
      ovf_q        <= 1'b0;
      sum_valid_q  <= 1'b0;
      prod_ready_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle, StAccum: begin
          prod_ready_q <= 1'b1;
          if (accept) begin
            acc_q    <= acc_add;
            count_q  <= count_next;
            sticky_q <= sticky_d;
            if (last_term) begin
              sum_q        <= acc_add;
              ovf_q        <= sticky_d;
              sum_valid_q  <= 1'b1;
              prod_ready_q <= 1'b0;
              state_q      <= StHold;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StHold: begin
          // Ready comes back one cycle after the handshake; no same-cycle bypass.
          if (i_sum_ready) begin
            sum_valid_q  <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            sticky_q     <= 1'b0;
            prod_ready_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q      <= StIdle;
          acc_q        <= '0;
          count_q      <= '0;
          sticky_q     <= 1'b0;
          sum_valid_q  <= 1'b0;
          prod_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_prod_ready = prod_ready_q;
  assign o_sum_valid  = sum_valid_q;
  assign o_sum        = sum_q;
  assign o_overflow   = ovf_q;
  assign o_term_count = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboarded random + directed bench for product_accumulator, with a second ACC_W=9 instance.
module tb_product_accumulator;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, pv, pr, sv, sr, ovf;
  logic [7:0]  prod, tc;
  logic [11:0] sum;

  logic        v9, r9, sv9, ovf9, pr9, sr9;
  logic [7:0]  p9, tc9;
  logic [8:0]  sum9;

  int checks = 0;
  int errors = 0;
  int sink_mode = 0;
  int cur[$];
  logic [12:0] sb[$];

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(8), .ACC_W(12), .N_TERMS(NT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_prod_valid(pv), .o_prod_ready(pr),
    .i_product(prod), .o_sum_valid(sv), .i_sum_ready(sr), .o_sum(sum), .o_overflow(ovf),
    .o_term_count(tc)
  );

  product_accumulator #(.PROD_W(8), .ACC_W(9), .N_TERMS(NT)) dut9 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_prod_valid(v9), .o_prod_ready(pr9),
    .i_product(p9), .o_sum_valid(sv9), .i_sum_ready(sr9), .o_sum(sum9), .o_overflow(ovf9),
    .o_term_count(tc9)
  );

  // Reference: true sum as an integer, then overflow / wrap / clamp from the result width.
  function automatic logic [12:0] expect_of(input int terms[$], input int w);
    int total = 0;
    int maxv  = (1 << w) - 1;
    logic o;
    int s;
    foreach (terms[i]) total += terms[i];
    o = (total > maxv);
`ifdef ACC_SATURATE_EN
    s = o ? maxv : total;
`else
    s = total % (1 << w);
`endif
    return {o, 12'(s)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input int p);
    cur.push_back(p);
    if (cur.size() == NT) begin
      sb.push_back(expect_of(cur, 12));
      cur.delete();
    end
  endtask

  task automatic send(input int p);
    int n = 0;
    logic ok;
    pv = 1'b1;
    prod = 8'(p);
    do begin
      @(negedge clk);
      ok = pr;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    pv = 1'b0;
    prod = 8'($urandom);
    if (!ok) check("send_timeout", 0, 1);
    else model_accept(p);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sink: i_sum_ready pattern, changed just after each rising edge.
  initial begin
    sr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       sr = 1'b0;
        1:       sr = 1'b1;
        default: sr = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected results on each output handshake; checks hold stability.
  logic        pend_q = 1'b0;
  logic [12:0] pend_val = '0;
  always @(negedge clk) begin
    logic [12:0] e;
    if (pend_q && sv) check("hold_stable", int'({ovf, sum}), int'(pend_val));
    if (sv) check("ready_low_in_hold", int'(pr), 0);
    if (sv && sr) begin
      if (sb.size() == 0) begin
        check("unexpected_result", int'(sum), -1);
      end else begin
        e = sb.pop_front();
        check("sum", int'(sum), int'(e[11:0]));
        check("overflow", int'(ovf), int'(e[12]));
      end
    end
    pend_q   = sv && !sr;
    pend_val = {ovf, sum};
  end

  initial begin
    logic [12:0] e9;
    int n;
    int seq9[$];
    rst_n = 1'b0; clear = 1'b0; pv = 1'b0; prod = '0;
    v9 = 1'b0; p9 = '0; sr9 = 1'b1;
    idle(2);
    check("rst_ready", int'(pr), 0);
    check("rst_valid", int'(sv), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_tc", int'(tc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_release", int'(pr), 1);

    // 1: reset mid-accumulation
    sink_mode = 1;
    send(5);
    send(6);
    check("tc_before_reset", int'(tc), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", int'(pr), 0);
    check("async_tc", int'(tc), 0);
    check("async_valid", int'(sv), 0);
    check("async_sum", int'(sum), 0);
    check("async_ovf", int'(ovf), 0);
    cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("post_reset_ready", int'(pr), 1);
    check("post_reset_tc", int'(tc), 0);

    // 2: back-to-back 225s, always-ready sink
    repeat (4) send(225);
    check("latency_valid", int'(sv), 1);
    check("latency_sum", int'(sum), 900);
    idle(1);
    check("valid_one_cycle", int'(sv), 0);
    check("ready_back", int'(pr), 1);

    // 3: consumer stalls; extra product must be refused
    sink_mode = 0;
    idle(1);
    send(10); send(20); send(30); send(40);
    pv = 1'b1;
    prod = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", int'(sv), 1);
      check("hold_sum", int'(sum), 100);
      check("hold_tc", int'(tc), NT);
      @(posedge clk);
      #1;
    end
    pv = 1'b0;
    sink_mode = 1;
    n = 0;
    while (sv && n < 20) begin idle(1); n++; end
    check("hold_release", int'(sv), 0);
    check("tc_after_release", int'(tc), 0);
    send(1); send(1); send(1); send(1);
    idle(2);

    // 4: narrow accumulator overflow
    for (int i = 0; i < 4; i++) begin
      v9 = 1'b1;
      p9 = 8'd225;
      @(negedge clk);
      check("ready9", int'(pr9), 1);
      @(posedge clk);
      #1;
      seq9.push_back(225);
    end
    v9 = 1'b0;
    e9 = expect_of(seq9, 9);
    @(negedge clk);
    check("valid9", int'(sv9), 1);
    check("sum9", int'(sum9), int'(e9[8:0]));
    check("ovf9", int'(ovf9), int'(e9[12]));
    idle(1);

    // 5: clear drops partial sum and concurrent product
    send(5); send(6);
    clear = 1'b1; pv = 1'b1; prod = 8'd7;
    idle(1);
    clear = 1'b0; pv = 1'b0;
    cur.delete();
    check("clear_tc", int'(tc), 0);
    check("clear_valid", int'(sv), 0);
    send(1); send(1); send(1); send(1);
    idle(2);

    // 6: every-other-cycle valid; count moves only on handshakes
    for (int i = 1; i <= 4; i++) begin
      send(i);
      check("tc_step", int'(tc), i);
      if (i < 4) begin
        idle(1);
        check("tc_hold", int'(tc), i);
      end
    end
    idle(2);

    // random traffic against a random sink
    sink_mode = 2;
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, 255)));
      idle(int'($urandom_range(0, 2)));
    end
    sink_mode = 1;
    n = 0;
    while ((sb.size() != 0 || sv) && n < 200) begin idle(1); n++; end
    check("scoreboard_drained", sb.size(), 0);
    check("partial_leftover", cur.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
